// File: rtl/mem_stage_pipe.sv
// Y86-64 memory stage: E/M pipeline register followed by a byte-addressed,
// little-endian data memory with 8-byte load/store and address checking.
module mem_stage_pipe #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_bubble,
    input  logic [1:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    output logic [3:0]  M_icode,
    output logic        M_cnd,
    output logic [63:0] M_valA,
    output logic [63:0] M_valE,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [1:0]  m_stat,
    output logic [3:0]  m_icode,
    output logic [63:0] m_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_dstE,
    output logic [3:0]  m_dstM
);

    localparam int          AW        = $clog2(DMEM_BYTES);
    localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_ADR = 2'd2;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [1:0]  stat_q,  stat_d;
    logic [3:0]  icode_q, icode_d;
    logic        cnd_q,   cnd_d;
    logic [63:0] valA_q,  valA_d;
    logic [63:0] valE_q,  valE_d;
    logic [3:0]  dstE_q,  dstE_d;
    logic [3:0]  dstM_q,  dstM_d;

    logic [7:0]  mem_q [DMEM_BYTES];

    logic          rdEn;
    logic          wrEn;
    logic [63:0]   memAddr;
    logic          addrOk;
    logic          wrCommit;
    logic [AW-1:0] memIdx;
    logic [63:0]   rdData;

    always_comb begin
        stat_d  = STAT_AOK;
        icode_d = I_NOP;
        cnd_d   = 1'b0;
        valA_d  = '0;
        valE_d  = '0;
        dstE_d  = REG_NONE;
        dstM_d  = REG_NONE;
        if (!M_bubble) begin
            stat_d  = e_stat;
            icode_d = e_icode;
            cnd_d   = e_cnd;
            valA_d  = e_valA;
            valE_d  = e_valE;
            dstE_d  = e_dstE;
            dstM_d  = e_dstM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= STAT_AOK;
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            valA_q  <= '0;
            valE_q  <= '0;
            dstE_q  <= REG_NONE;
            dstM_q  <= REG_NONE;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            valA_q  <= valA_d;
            valE_q  <= valE_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
        end
    end

    // Stack pops take their address from valA; everything else uses valE.
    always_comb begin
        rdEn    = 1'b0;
        wrEn    = 1'b0;
        memAddr = valE_q;
        case (icode_q)
            I_MRMOVQ:                  rdEn = 1'b1;
            I_RET, I_POPQ: begin
                rdEn    = 1'b1;
                memAddr = valA_q;
            end
            I_RMMOVQ, I_PUSHQ, I_CALL: wrEn = 1'b1;
            default: ;
        endcase
    end

    assign addrOk   = (memAddr <= LAST_ADDR);
    assign memIdx   = memAddr[AW-1:0];
    assign wrCommit = wrEn && addrOk && (stat_q == STAT_AOK);

    always_comb begin
        rdData = '0;
        for (int k = 0; k < 8; k++) begin
            rdData[8*k +: 8] = mem_q[memIdx + AW'(k)];
        end
    end

    // Memory is deliberately outside the async-reset domain so rst never clears it.
    always_ff @(posedge clk) begin
        if (!rst && wrCommit) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[memIdx + AW'(k)] <= valA_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        m_stat = STAT_AOK;
        if (stat_q != STAT_AOK) begin
            m_stat = stat_q;
        end else if ((rdEn || wrEn) && !addrOk) begin
            m_stat = STAT_ADR;
        end
    end

    assign m_valM  = (rdEn && addrOk) ? rdData : 64'd0;

    assign M_icode = icode_q;
    assign M_cnd   = cnd_q;
    assign M_valA  = valA_q;
    assign M_valE  = valE_q;
    assign M_dstE  = dstE_q;
    assign M_dstM  = dstM_q;

    assign m_icode = icode_q;
    assign m_valE  = valE_q;
    assign m_dstE  = dstE_q;
    assign m_dstM  = dstM_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: a byte-array reference model predicts
// each instruction's memory-stage outputs; a monitor compares one cycle later.
module tb_mem_stage_pipe;

    typedef struct {
        logic        bubble;
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } instr_t;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valA;
        logic [63:0] valE;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [1:0]  stat;
        logic [63:0] valM;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        M_bubble;
    logic [1:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [63:0] M_valE;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    logic [7:0] refMem [1024];

    mem_stage_pipe #(.DMEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .M_bubble(M_bubble),
        .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA), .M_valE(M_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic instr_t mk(input logic bubble, input logic [1:0] stat, input logic [3:0] icode,
                                  input logic cnd, input logic [63:0] valE, input logic [63:0] valA,
                                  input logic [3:0] dstE, input logic [3:0] dstM);
        instr_t r;
        r.bubble = bubble; r.stat = stat; r.icode = icode; r.cnd = cnd;
        r.valE = valE; r.valA = valA; r.dstE = dstE; r.dstM = dstM;
        return r;
    endfunction

    // Instruction-level model: decide the access, check the 8-byte window, then update memory.
    function automatic exp_t modelStep(input instr_t in);
        exp_t        e;
        logic [63:0] addr;
        logic        isRead, isWrite, inRange;
        if (in.bubble) begin
            e.stat = 2'd0; e.icode = 4'h1; e.cnd = 1'b0; e.valA = 64'd0; e.valE = 64'd0;
            e.dstE = 4'hF; e.dstM = 4'hF;
        end else begin
            e.stat = in.stat; e.icode = in.icode; e.cnd = in.cnd; e.valA = in.valA; e.valE = in.valE;
            e.dstE = in.dstE; e.dstM = in.dstM;
        end
        isRead  = (e.icode == 4'h5) || (e.icode == 4'h9) || (e.icode == 4'hB);
        isWrite = (e.icode == 4'h4) || (e.icode == 4'h8) || (e.icode == 4'hA);
        addr    = (e.icode == 4'h9 || e.icode == 4'hB) ? e.valA : e.valE;
        inRange = (addr <= 64'd1016);
        e.valM  = 64'd0;
        if (isRead && inRange) begin
            for (int b = 0; b < 8; b++) e.valM = e.valM | (64'(refMem[int'(addr) + b]) << (8 * b));
        end
        if (e.stat == 2'd0 && (isRead || isWrite) && !inRange) e.stat = 2'd2;
        if (isWrite && inRange && e.stat == 2'd0) begin
            for (int b = 0; b < 8; b++) refMem[int'(addr) + b] = 8'((e.valA >> (8 * b)) & 64'hFF);
        end
        return e;
    endfunction

    task automatic driveInputs(input instr_t in);
        M_bubble = in.bubble; e_stat = in.stat; e_icode = in.icode; e_cnd = in.cnd;
        e_valE = in.valE; e_valA = in.valA; e_dstE = in.dstE; e_dstM = in.dstM;
    endtask

    task automatic applyStimulus(input instr_t in);
        @(posedge clk);
        #1;
        driveInputs(in);
        expQ.push_back(modelStep(in));
    endtask

    // Drives a nop without scoreboarding it and lets the last queued item be checked.
    task automatic quiesce();
        @(posedge clk);
        #1;
        driveInputs(mk(1'b0, 2'd0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF));
        @(negedge clk);
    endtask

    function automatic logic [63:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5)       return 64'($urandom_range(0, 15)) * 64'd8;
        else if (sel < 7)  return 64'($urandom_range(0, 120));
        else if (sel == 7) return 64'h3F8;
        else if (sel == 8) return 64'($urandom_range(1017, 1100));
        else               return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    endfunction

    initial begin : monitor
        exp_t e;
        bit   have;
        forever begin
            @(posedge clk);
            have = (expQ.size() > 0);
            @(negedge clk);
            if (have) begin
                e = expQ.pop_front();
                checkOutput("M_icode", 64'(M_icode), 64'(e.icode));
                checkOutput("M_cnd",   64'(M_cnd),   64'(e.cnd));
                checkOutput("M_valA",  M_valA,       e.valA);
                checkOutput("M_valE",  M_valE,       e.valE);
                checkOutput("M_dstE",  64'(M_dstE),  64'(e.dstE));
                checkOutput("M_dstM",  64'(M_dstM),  64'(e.dstM));
                checkOutput("m_stat",  64'(m_stat),  64'(e.stat));
                checkOutput("m_icode", 64'(m_icode), 64'(e.icode));
                checkOutput("m_valE",  m_valE,       e.valE);
                checkOutput("m_valM",  m_valM,       e.valM);
                checkOutput("m_dstE",  64'(m_dstE),  64'(e.dstE));
                checkOutput("m_dstM",  64'(m_dstM),  64'(e.dstM));
            end
        end
    end

    initial begin : driver
        instr_t in;
        int     budget;
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        rst = 1'b1;
        driveInputs(mk(1'b0, 2'd0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF));
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_M_icode", 64'(M_icode), 64'h1);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_M_icode", 64'(M_icode), 64'h1);
        checkOutput("post_rst_M_dstE",  64'(M_dstE),  64'hF);
        checkOutput("post_rst_M_dstM",  64'(M_dstM),  64'hF);
        checkOutput("post_rst_m_stat",  64'(m_stat),  64'h0);
        checkOutput("post_rst_m_valM",  m_valM,       64'h0);

        applyStimulus(mk(0, 0, 4'h4, 0, 64'h10, 64'h1122334455667788, 4'hF, 4'hF));
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h10, 64'h0, 4'hF, 4'h3));
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h17, 64'h0, 4'hF, 4'h2));
        applyStimulus(mk(0, 0, 4'hA, 0, 64'h3F8, 64'hAB, 4'h4, 4'hF));
        applyStimulus(mk(0, 0, 4'hB, 0, 64'h400, 64'h3F8, 4'h4, 4'h1));
        applyStimulus(mk(0, 0, 4'h9, 0, 64'h400, 64'h3F8, 4'h4, 4'hF));
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h3F9, 64'h0, 4'hF, 4'h5));
        applyStimulus(mk(0, 0, 4'h4, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_0000_1111, 4'hF, 4'hF));
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h3F8, 64'h0, 4'hF, 4'h6));
        applyStimulus(mk(0, 0, 4'h4, 0, 64'h30, 64'h0102030405060708, 4'hF, 4'hF));
        applyStimulus(mk(0, 2'd1, 4'h4, 0, 64'h30, 64'hFFFF_0000_FFFF_0000, 4'hF, 4'hF));
        applyStimulus(mk(1, 0, 4'h4, 1, 64'h30, 64'h5555_5555_5555_5555, 4'h2, 4'h3));
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h30, 64'h0, 4'hF, 4'h7));
        applyStimulus(mk(0, 0, 4'h7, 1, 64'h0, 64'h40, 4'hF, 4'hF));
        applyStimulus(mk(0, 0, 4'h4, 0, 64'h100, 64'h0BAD_F00D_CAFE_BABE, 4'hF, 4'hF));

        quiesce();
        @(posedge clk);
        #1;
        driveInputs(mk(0, 0, 4'h4, 0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF));
        @(posedge clk);
        #1;
        checkOutput("store_in_M_icode", 64'(M_icode), 64'h4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_M_icode", 64'(M_icode), 64'h1);
        checkOutput("midrst_M_valA",  M_valA,       64'h0);
        checkOutput("midrst_M_dstM",  64'(M_dstM),  64'hF);
        driveInputs(mk(0, 0, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(0, 0, 4'h5, 0, 64'h100, 64'h0, 4'hF, 4'h8));

        for (int s = 0; s < 16; s++) begin
            applyStimulus(mk(0, 0, 4'h4, 0, 64'(s) * 64'd8, {$urandom, $urandom}, 4'hF, 4'hF));
        end
        for (int n = 0; n < 400; n++) begin
            in.bubble = ($urandom_range(0, 9) == 0);
            in.stat   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            in.icode  = 4'($urandom_range(0, 11));
            in.cnd    = 1'($urandom);
            in.valE   = randAddr();
            in.valA   = ($urandom_range(0, 1) == 0) ? randAddr() : {$urandom, $urandom};
            in.dstE   = 4'($urandom);
            in.dstM   = 4'($urandom);
            applyStimulus(in);
        end

        @(posedge clk);
        #1;
        driveInputs(mk(0, 0, 4'h1, 0, 64'd0, 64'd0, 4'hF, 4'hF));
        budget = 0;
        while (expQ.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
